// File: rtl/mips_pkg.sv
// Shared MIPS core constants: opcodes, register-field width and the MDU FSM state type.
package mips_pkg;

    localparam logic [5:0] OP_ALU = 6'b000000;
    localparam logic [5:0] OP_MDU = 6'b011100;
    localparam int         REG_W  = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_WAIT = 2'd1,
        MDU_WB   = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mdu_scoreboard.sv
// MDU completion timer and GPR scoreboard; only compiled when HAZARD_MDU_EN is defined.
`ifdef HAZARD_MDU_EN
module mdu_scoreboard
    import mips_pkg::*;
#(
    parameter int MDU_LAT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [REG_W-1:0] rd,
    output logic             busy,
    output logic             wb_valid,
    output logic [REG_W-1:0] wb_rd,
    output logic [31:0]      pending
);

    mdu_state_t       state;
    mdu_state_t       next_state;
    logic [3:0]       cnt;
    logic [REG_W-1:0] rd_q;
    logic [31:0]      pending_q;
    logic [31:0]      pending_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN:      if (start) next_state = MDU_WAIT;
            MDU_WAIT: if (cnt == 4'd0) next_state = MDU_WB;
            MDU_WB:   next_state = RUN;
            default:  next_state = RUN;
        endcase
    end

    always_comb begin
        busy     = (state != RUN);
        wb_valid = (state == MDU_WB);
        wb_rd    = (state == MDU_WB) ? rd_q : '0;
    end

    // A start seen while busy is ignored, so set and clear never target the same edge.
    always_comb begin
        pending_next = pending_q;
        if (state == MDU_WB) begin
            pending_next[rd_q] = 1'b0;
        end
        if (state == RUN && start && rd != '0) begin
            pending_next[rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 4'd0;
            rd_q      <= '0;
            pending_q <= '0;
        end else begin
            pending_q <= pending_next;
            if (state == RUN && start) begin
                cnt  <= 4'(MDU_LAT - 2);
                rd_q <= rd;
            end else if (state == MDU_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign pending = pending_q;

endmodule
`endif

// File: rtl/hazard_stall_unit.sv
// Pipeline interlock: load-use stall plus, with HAZARD_MDU_EN defined, MDU RAW/structural stalls.
module hazard_stall_unit
    import mips_pkg::*;
#(
    parameter int MDU_LAT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       id_op,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rt_used,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    input  logic             idex_mdu_start,
    input  logic [REG_W-1:0] idex_rd,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             bubble_idex,
    output logic             mdu_busy,
    output logic             mdu_wb_valid,
    output logic [REG_W-1:0] mdu_wb_rd
);

    logic load_use;
    logic mdu_stall;
    logic stall;

    assign load_use = idex_memread && (idex_rt != '0) &&
                      ((idex_rt == id_rs) || (id_rt_used && (idex_rt == id_rt)));

`ifdef HAZARD_MDU_EN
    logic [31:0] pending;
    logic        raw_pending;
    logic        raw_start;
    logic        structural;

    mdu_scoreboard #(.MDU_LAT(MDU_LAT)) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (idex_mdu_start),
        .rd       (idex_rd),
        .busy     (mdu_busy),
        .wb_valid (mdu_wb_valid),
        .wb_rd    (mdu_wb_rd),
        .pending  (pending)
    );

    // The op starting in EX this cycle has not reached the scoreboard yet, so compare it directly.
    assign raw_pending = pending[id_rs] || (id_rt_used && pending[id_rt]);
    assign raw_start   = idex_mdu_start && (idex_rd != '0) &&
                         ((idex_rd == id_rs) || (id_rt_used && (idex_rd == id_rt)));
    assign structural  = (id_op == OP_MDU) && (mdu_busy || idex_mdu_start);
    assign mdu_stall   = raw_pending || raw_start || structural;
`else
    logic unused_mdu;

    assign unused_mdu   = ^{clk, id_op, idex_mdu_start, idex_rd};
    assign mdu_stall    = 1'b0;
    assign mdu_busy     = 1'b0;
    assign mdu_wb_valid = 1'b0;
    assign mdu_wb_rd    = '0;
`endif

    assign stall       = load_use || mdu_stall;
    assign stall_pc    = stall;
    assign stall_ifid  = stall;
    assign bubble_idex = stall;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed self-checking bench for hazard_stall_unit; MDU checks run when HAZARD_MDU_EN is defined.
module tb_hazard_stall_unit;
    import mips_pkg::*;

    localparam int LAT = 4;

    logic       clk;
    logic       rst_n;
    logic [5:0] id_op;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_rt_used;
    logic       idex_memread;
    logic [4:0] idex_rt;
    logic       idex_mdu_start;
    logic [4:0] idex_rd;
    logic       stall_pc;
    logic       stall_ifid;
    logic       bubble_idex;
    logic       mdu_busy;
    logic       mdu_wb_valid;
    logic [4:0] mdu_wb_rd;

    int tests_run;
    int tests_failed;

    hazard_stall_unit #(.MDU_LAT(LAT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_op          (id_op),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rt_used     (id_rt_used),
        .idex_memread   (idex_memread),
        .idex_rt        (idex_rt),
        .idex_mdu_start (idex_mdu_start),
        .idex_rd        (idex_rd),
        .stall_pc       (stall_pc),
        .stall_ifid     (stall_ifid),
        .bubble_idex    (bubble_idex),
        .mdu_busy       (mdu_busy),
        .mdu_wb_valid   (mdu_wb_valid),
        .mdu_wb_rd      (mdu_wb_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic rt_used, input logic memread, input logic [4:0] ex_rt,
                                 input logic start, input logic [4:0] rd);
        id_op          = op;
        id_rs          = rs;
        id_rt          = rt;
        id_rt_used     = rt_used;
        idex_memread   = memread;
        idex_rt        = ex_rt;
        idex_mdu_start = start;
        idex_rd        = rd;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkStall(input string tag, input logic expected);
        checkOutput({tag, ".stall_pc"}, 32'(stall_pc), 32'(expected));
        checkOutput({tag, ".stall_ifid"}, 32'(stall_ifid), 32'(expected));
        checkOutput({tag, ".bubble_idex"}, 32'(bubble_idex), 32'(expected));
    endtask

    task automatic checkMdu(input string tag, input logic busy, input logic wbv, input logic [4:0] wbrd);
        checkOutput({tag, ".mdu_busy"}, 32'(mdu_busy), 32'(busy));
        checkOutput({tag, ".mdu_wb_valid"}, 32'(mdu_wb_valid), 32'(wbv));
        checkOutput({tag, ".mdu_wb_rd"}, 32'(mdu_wb_rd), 32'(wbrd));
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        applyStimulus(OP_ALU, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkStall("reset_idle", 1'b0);
        checkMdu("reset_idle", 1'b0, 1'b0, 5'd0);
        applyStimulus(OP_ALU, 5'd9, 5'd11, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0);
        checkStall("reset_loaduse_comb", 1'b1);
        applyStimulus(OP_ALU, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        nextCycle();
        rst_n = 1'b1;
        nextCycle();

        // Load-use on rs, then the bubble removes the load from EX.
        applyStimulus(OP_ALU, 5'd9, 5'd11, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0);
        checkStall("lu_rs", 1'b1);
        nextCycle();
        applyStimulus(OP_ALU, 5'd9, 5'd11, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
        checkStall("lu_rs_release", 1'b0);
        nextCycle();
        applyStimulus(OP_ALU, 5'd10, 5'd11, 1'b1, 1'b1, 5'd11, 1'b0, 5'd0);
        checkStall("lu_rt_used", 1'b1);
        applyStimulus(OP_ALU, 5'd10, 5'd11, 1'b0, 1'b1, 5'd11, 1'b0, 5'd0);
        checkStall("lu_rt_unused", 1'b0);
        applyStimulus(OP_ALU, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0);
        checkStall("lu_zero_reg", 1'b0);
        applyStimulus(OP_ALU, 5'd6, 5'd7, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0);
        checkStall("lu_no_match", 1'b0);
        applyStimulus(OP_ALU, 5'd5, 5'd7, 1'b1, 1'b0, 5'd5, 1'b0, 5'd0);
        checkStall("lu_no_load", 1'b0);
        nextCycle();

`ifdef HAZARD_MDU_EN
        // Cycle T: MDU op with rd=$8 enters EX; a same-cycle reader of $8 stalls.
        applyStimulus(OP_ALU, 5'd8, 5'd3, 1'b1, 1'b0, 5'd0, 1'b1, 5'd8);
        checkStall("T_raw_start", 1'b1);
        checkMdu("T", 1'b0, 1'b0, 5'd0);
        applyStimulus(OP_ALU, 5'd9, 5'd3, 1'b1, 1'b0, 5'd0, 1'b1, 5'd8);
        checkStall("T_indep", 1'b0);
        applyStimulus(OP_MDU, 5'd9, 5'd3, 1'b1, 1'b0, 5'd0, 1'b1, 5'd8);
        checkStall("T_struct_start", 1'b1);
        nextCycle();
        for (int c = 1; c <= LAT; c++) begin
            applyStimulus(OP_ALU, 5'd8, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
            checkStall($sformatf("T%0d_raw_rs", c), 1'b1);
            checkMdu($sformatf("T%0d", c), 1'b1, (c == LAT), (c == LAT) ? 5'd8 : 5'd0);
            applyStimulus(OP_ALU, 5'd9, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
            checkStall($sformatf("T%0d_indep", c), 1'b0);
            applyStimulus(OP_ALU, 5'd2, 5'd8, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
            checkStall($sformatf("T%0d_rt_unused", c), 1'b0);
            applyStimulus(OP_MDU, 5'd9, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
            checkStall($sformatf("T%0d_struct", c), 1'b1);
            nextCycle();
        end
        // T+5: scoreboard cleared, busy dropped.
        applyStimulus(OP_ALU, 5'd2, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
        checkStall("T5_raw_rt", 1'b0);
        applyStimulus(OP_MDU, 5'd9, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
        checkStall("T5_struct", 1'b0);
        checkMdu("T5", 1'b0, 1'b0, 5'd0);
        nextCycle();
        // T+6: second MDU op starts with rd=$12; write-back at T+6+LAT.
        applyStimulus(OP_ALU, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd12);
        nextCycle();
        applyStimulus(OP_ALU, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        for (int c = 1; c < LAT; c++) begin
            checkMdu($sformatf("op2_c%0d", c), 1'b1, 1'b0, 5'd0);
            nextCycle();
        end
        checkMdu("op2_wb", 1'b1, 1'b1, 5'd12);
        nextCycle();
        checkMdu("op2_done", 1'b0, 1'b0, 5'd0);
        nextCycle();

        // Reset asserted at S+2 of an MDU op with rd=$5.
        applyStimulus(OP_ALU, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5);
        nextCycle();
        applyStimulus(OP_ALU, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkStall("rst_pre_raw", 1'b1);
        nextCycle();
        checkMdu("rst_pre", 1'b1, 1'b0, 5'd0);
        rst_n = 1'b0;
        #1;
        checkMdu("rst_mid", 1'b0, 1'b0, 5'd0);
        checkStall("rst_mid_pending", 1'b0);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < LAT + 2; c++) begin
            nextCycle();
            checkMdu($sformatf("rst_after_%0d", c), 1'b0, 1'b0, 5'd0);
            checkStall($sformatf("rst_after_%0d", c), 1'b0);
        end
`else
        // MDU logic absent: its outputs stay 0 and MDU inputs cause no stall.
        applyStimulus(OP_MDU, 5'd8, 5'd3, 1'b1, 1'b0, 5'd0, 1'b1, 5'd8);
        checkStall("nomdu_start", 1'b0);
        for (int c = 1; c <= LAT + 1; c++) begin
            nextCycle();
            applyStimulus(OP_MDU, 5'd8, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
            checkStall($sformatf("nomdu_c%0d", c), 1'b0);
            checkMdu($sformatf("nomdu_c%0d", c), 1'b0, 1'b0, 5'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
